manchester_encoder_axis: RTL

Parametrised Manchester transmitter and the next generation of the fixed-pattern serial sender. It accepts frames of FRAME_SIZE bits on an AXI-Stream slave and prepends a configurable sync word. Each bit is Manchester-encoded at a programmable number of clocks per half-bit, and a configurable inter-frame gap follows each frame. It drives the single-ended line feeding the differential output buffer, and pairs with the Manchester decoder on the receive side.

---
 rtl/manchester_encoder_axis.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/manchester_encoder_axis.sv
// Manchester transmitter: takes one frame per AXI-Stream handshake and sends
// sync word, Manchester-coded payload and an idle gap on a single registered line.
module manchester_encoder_axis #(
    parameter int unsigned FRAME_SIZE    = 8,
    parameter int unsigned HALF_BIT_CLKS = 1,
    parameter int unsigned SYNC_WIDTH    = 8,
    parameter logic [((SYNC_WIDTH > 0) ? SYNC_WIDTH : 1)-1:0] SYNC_WORD = 8'hD5,
    parameter int unsigned GAP_BITS      = 2,
    parameter bit          MSB_FIRST     = 1'b1,
    parameter bit          CONVENTION    = 1'b0,
    parameter bit          IDLE_LEVEL    = 1'b0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [FRAME_SIZE-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic                  manchester_out,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frames_sent
);
    localparam int unsigned SW1      = (SYNC_WIDTH > 0) ? SYNC_WIDTH : 1;
    localparam int unsigned MAX_BITS = (SYNC_WIDTH > FRAME_SIZE) ? SYNC_WIDTH : FRAME_SIZE;
    localparam int unsigned IDX_W    = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;
    localparam int unsigned CNT_W    = (HALF_BIT_CLKS > 1) ? $clog2(HALF_BIT_CLKS) : 1;
    localparam int unsigned GAP_CLKS = GAP_BITS * 2 * HALF_BIT_CLKS;
    localparam int unsigned GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam int unsigned GAP_LAST = (GAP_CLKS > 0) ? GAP_CLKS - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC,
        ST_DATA,
        ST_GAP
    } state_t;

    state_t                state_q, state_d;
    logic [FRAME_SIZE-1:0] data_q, data_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  line_q, line_d;
    logic                  tready_q, tready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [15:0]           sent_q, sent_d;

    logic half_end, bit_end;
    logic sync_bit, data_bit, cur_bit;

    // Next-state logic; the line value is derived from the *next* position so
    // the first half-bit is on the line the cycle after the handshake.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        phase_d  = phase_q;
        idx_d    = idx_q;
        gap_d    = gap_q;
        tready_d = tready_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sent_d   = sent_q;
        half_end = (cnt_q == CNT_W'(HALF_BIT_CLKS - 1));
        bit_end  = half_end && phase_q;

        unique case (state_q)
            ST_IDLE: begin
                tready_d = 1'b1;
                busy_d   = 1'b0;
                if (s_axis_tvalid && tready_q) begin
                    data_d   = s_axis_tdata;
                    tready_d = 1'b0;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    phase_d  = 1'b0;
                    idx_d    = '0;
                    state_d  = (SYNC_WIDTH > 0) ? ST_SYNC : ST_DATA;
                end
            end
            ST_SYNC, ST_DATA: begin
                if (half_end) begin
                    cnt_d   = '0;
                    phase_d = ~phase_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (bit_end) begin
                    idx_d = idx_q + 1'b1;
                    if (state_q == ST_SYNC && idx_q == IDX_W'(SW1 - 1)) begin
                        idx_d   = '0;
                        state_d = ST_DATA;
                    end
                    if (state_q == ST_DATA && idx_q == IDX_W'(FRAME_SIZE - 1)) begin
                        idx_d  = '0;
                        gap_d  = '0;
                        done_d = 1'b1;
                        sent_d = sent_q + 16'd1;
                        if (GAP_BITS > 0) begin
                            state_d = ST_GAP;
                        end else begin
                            state_d  = ST_IDLE;
                            tready_d = 1'b1;
                            busy_d   = 1'b0;
                        end
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_W'(GAP_LAST)) begin
                    gap_d    = '0;
                    state_d  = ST_IDLE;
                    tready_d = 1'b1;
                    busy_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        sync_bit = 1'b0;
        for (int i = 0; i < int'(SW1); i++) begin
            if (int'(idx_d) == int'(SW1) - 1 - i) sync_bit = SYNC_WORD[i];
        end
        data_bit = 1'b0;
        for (int i = 0; i < int'(FRAME_SIZE); i++) begin
            if (int'(idx_d) == (MSB_FIRST ? int'(FRAME_SIZE) - 1 - i : i)) data_bit = data_d[i];
        end
        cur_bit = (state_d == ST_SYNC) ? sync_bit : data_bit;

        line_d = IDLE_LEVEL;
        if (state_d == ST_SYNC || state_d == ST_DATA) line_d = cur_bit ^ ~phase_d ^ CONVENTION;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q  <= ST_IDLE;
            data_q   <= '0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
            idx_q    <= '0;
            gap_q    <= '0;
            line_q   <= IDLE_LEVEL;
            tready_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sent_q   <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
            idx_q    <= idx_d;
            gap_q    <= gap_d;
            line_q   <= line_d;
            tready_q <= tready_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            sent_q   <= sent_d;
        end
    end

    assign s_axis_tready  = tready_q;
    assign manchester_out = line_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign frames_sent    = sent_q;

endmodule
